// File: rtl/iir_deemph.sv
// iir_deemph: per-channel de-emphasis IIR between an input FWFT FIFO and the gain-stage FIFO.
// Each iteration pops one sample, runs TAPS multiply-accumulate cycles, sums and pushes one result.
//
// state   | meaning
// S_READ  | wait for an input sample; pop it and shift the histories
// S_MAC   | one feed-forward and one feedback tap per cycle
// S_SUM   | combine the two accumulators into the output register
// S_WRITE | present the result; push when downstream has room
module iir_deemph #(
  parameter int DATA_SIZE = 32,
  parameter int TAPS      = 2,
  parameter int BITS      = 10,
  parameter logic [DATA_SIZE-1:0] X_COEFFS [TAPS] = '{32'h000000B2, 32'h000000B2},
  parameter logic [DATA_SIZE-1:0] Y_COEFFS [TAPS] = '{32'h00000000, 32'hFFFFFD66}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 x_in_empty,
  output logic                 x_in_rd_en,
  input  logic [DATA_SIZE-1:0] x_in_dout,
  input  logic                 y_out_full,
  output logic                 y_out_wr_en,
  output logic [DATA_SIZE-1:0] y_out_din
);

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW    = 2 * DATA_SIZE;
  localparam logic signed [PW-1:0] BIAS = PW'((1 << BITS) - 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_SUM   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_SIZE-1:0] x_hist [TAPS];
  logic signed [DATA_SIZE-1:0] y_hist [TAPS];
  logic signed [DATA_SIZE-1:0] sum_x, sum_y, y_reg;
  logic signed [DATA_SIZE-1:0] term_x, term_y;
  logic [TAP_W-1:0]            tap;
  logic                        pop, push, last_tap;

  // Full-width signed product, then divide by 2**BITS truncating toward zero (C semantics):
  // negative products get a bias of 2**BITS-1 before the arithmetic shift.
  function automatic logic signed [DATA_SIZE-1:0] mac_term(
    input logic signed [DATA_SIZE-1:0] coef,
    input logic signed [DATA_SIZE-1:0] val
  );
    logic signed [PW-1:0] coef_w, val_w, prod, biased, shifted;
    coef_w  = {{DATA_SIZE{coef[DATA_SIZE-1]}}, coef};
    val_w   = {{DATA_SIZE{val[DATA_SIZE-1]}}, val};
    prod    = coef_w * val_w;
    biased  = prod[PW-1] ? (prod + BIAS) : prod;
    shifted = biased >>> BITS;
    return shifted[DATA_SIZE-1:0];
  endfunction

  assign last_tap  = (tap == LAST_TAP);
  assign term_x    = mac_term(X_COEFFS[tap], x_hist[tap]);
  assign term_y    = mac_term(Y_COEFFS[tap], y_hist[tap]);
  assign pop       = x_in_rd_en;
  assign push      = y_out_wr_en;
  assign y_out_din = y_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_READ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    x_in_rd_en  = 1'b0;
    y_out_wr_en = 1'b0;
    case (state)
      S_READ: begin
        x_in_rd_en = !x_in_empty;
        if (!x_in_empty) state_nxt = S_MAC;
      end
      S_MAC: begin
        if (last_tap) state_nxt = S_SUM;
      end
      S_SUM: begin
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        y_out_wr_en = !y_out_full;
        if (!y_out_full) state_nxt = S_READ;
      end
      default: state_nxt = S_READ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x_hist[i] <= '0;
        y_hist[i] <= '0;
      end
      sum_x <= '0;
      sum_y <= '0;
      y_reg <= '0;
      tap   <= '0;
    end else begin
      if (pop) begin
        for (int i = TAPS - 1; i > 0; i--) begin
          x_hist[i] <= x_hist[i-1];
          y_hist[i] <= y_hist[i-1];
        end
        x_hist[0] <= x_in_dout;
        // Slot 0 of the feedback history holds the output still being computed.
        y_hist[0] <= '0;
        sum_x     <= '0;
        sum_y     <= '0;
        tap       <= '0;
      end
      if (state == S_MAC) begin
        sum_x <= sum_x + term_x;
        sum_y <= sum_y + term_y;
        if (!last_tap) tap <= tap + TAP_W'(1);
      end
      if (state == S_SUM) y_reg <= sum_x + sum_y;
      if (push) y_hist[0] <= y_reg;
    end
  end

endmodule
